// File: rtl/mult_pkg.sv
// Shared width and helpers for the signed add-shift multiplier datapath.
package mult_pkg;

    localparam int DATA_W = 8;

    // Per-edge command bundle, gathered from the control FSM's strobes.
    typedef struct packed {
        logic clr_a;
        logic clr_x;
        logic clear_load;
        logic ld_a;
        logic shift;
    } cmd_t;

    function automatic logic [DATA_W:0] sext(input logic [DATA_W-1:0] v);
        return {v[DATA_W-1], v};
    endfunction

endpackage

// File: rtl/add_sub9.sv
// Sign-extended ripple add/subtract: Sum = A +/- (Add_En ? S : 0), one bit wider than the operands.
module add_sub9
    import mult_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] S,
    input  logic              sub,
    input  logic              Add_En,
    output logic [DATA_W:0]   Sum
);

    localparam int N = DATA_W + 1;

    logic [N-1:0] op_a;
    logic [N-1:0] op_s;
    logic [N-1:0] op_b;
    logic [N-1:0] c;

    assign op_a = sext(A);
    assign op_s = Add_En ? sext(S) : '0;
    // Two's-complement subtract: invert the operand and inject sub as carry-in.
    assign op_b = op_s ^ {N{sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign Sum[i] = op_a[i] ^ op_b[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (op_a[i] & op_b[i]) | (c[i] & (op_a[i] ^ op_b[i]));
        end
    end

endmodule

// File: rtl/mult_datapath.sv
// X/A/B/S register file and priority update mux for the add-shift multiplier.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] SW,
    input  logic         ClearA_LoadB,
    input  logic         Reset_A,
    input  logic         Reset_X,
    input  logic         Ld_A,
    input  logic         sub,
    input  logic         Add_En,
    input  logic         Shift_En,
    output logic [W-1:0] Aval,
    output logic [W-1:0] Bval,
    output logic         X,
    output logic         M
);

    logic [W-1:0] a_q, b_q, s_q;
    logic         x_q;
    logic [W-1:0] a_d, b_d, s_d;
    logic         x_d;
    logic [W:0]   sum;
    cmd_t         cmd;

    assign cmd = '{clr_a: Reset_A, clr_x: Reset_X, clear_load: ClearA_LoadB,
                   ld_a: Ld_A, shift: Shift_En};

    add_sub9 u_add (
        .A      (a_q),
        .S      (s_q),
        .sub    (sub),
        .Add_En (Add_En),
        .Sum    (sum)
    );

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        x_d = x_q;
        if (cmd.clr_a || cmd.clr_x) begin
            if (cmd.clr_a) a_d = '0;
            if (cmd.clr_x) x_d = 1'b0;
            // B still shifts, fed by A[0] as it was before the clear.
            if (cmd.shift) b_d = {a_q[0], b_q[W-1:1]};
        end else if (cmd.clear_load) begin
            s_d = SW;
            b_d = SW;
            a_d = '0;
            x_d = 1'b0;
        end else if (cmd.ld_a) begin
            a_d = sum[W-1:0];
            x_d = sum[W];
        end else if (cmd.shift) begin
            a_d = {x_q, a_q[W-1:1]};
            b_d = {a_q[0], b_q[W-1:1]};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            x_q <= x_d;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: reset, FSM-style multiplies, priority corner cases.
module tb_mult_datapath;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] SW = '0;
    logic       ClearA_LoadB = 1'b0, Reset_A = 1'b0, Reset_X = 1'b0;
    logic       Ld_A = 1'b0, sub = 1'b0, Add_En = 1'b0, Shift_En = 1'b0;
    logic [7:0] Aval, Bval;
    logic       X, M;

    int checks = 0;
    int errors = 0;

    mult_datapath #(.W(8)) dut (
        .Clk(Clk), .Reset(Reset), .SW(SW), .ClearA_LoadB(ClearA_LoadB),
        .Reset_A(Reset_A), .Reset_X(Reset_X), .Ld_A(Ld_A), .sub(sub),
        .Add_En(Add_En), .Shift_En(Shift_En),
        .Aval(Aval), .Bval(Bval), .X(X), .M(M)
    );

    always #5 Clk = ~Clk;

    // The control FSM never issues add and shift together.
    always @(posedge Clk) begin
        assert (!(Ld_A && Shift_En)) else begin
            errors++;
            $error("FAIL ld_shift_overlap obs=1 exp=0");
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_raw(input logic ca, input logic ra, input logic rx, input logic la,
                          input logic su, input logic ae, input logic sh);
        ClearA_LoadB = ca; Reset_A = ra; Reset_X = rx; Ld_A = la;
        sub = su; Add_En = ae; Shift_En = sh;
        @(posedge Clk);
        #1;
        ClearA_LoadB = 0; Reset_A = 0; Reset_X = 0; Ld_A = 0;
        sub = 0; Add_En = 0; Shift_En = 0;
    endtask

    task automatic do_load(input logic [7:0] v);
        SW = v;
        do_raw(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_add(input logic su, input logic ae);
        do_raw(0, 0, 0, 1, su, ae, 0);
    endtask

    task automatic do_shift(input int n);
        for (int i = 0; i < n; i++) do_raw(0, 0, 0, 0, 0, 0, 1);
    endtask

    // FSM replay: clear A/X, then 8 add/shift pairs; add7 subtracts. SW wanders meanwhile.
    task automatic run_mult();
        do_raw(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            SW = 8'($urandom);
            do_add(i == 7, M);
            do_shift(1);
        end
    endtask

    initial begin
        // Reset held low from time zero.
        #7;
        chk("rst_a", 16'(Aval), 16'h00);
        chk("rst_b", 16'(Bval), 16'h00);
        chk("rst_x", 16'(X), 16'h0);
        chk("rst_m", 16'(M), 16'h0);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;

        // Second load overwrites the first; 3 * 3.
        do_load(8'h07);
        do_load(8'h03);
        chk("ld_b", 16'(Bval), 16'h03);
        chk("ld_a", 16'(Aval), 16'h00);
        run_mult();
        chk("p3x3", {Aval, Bval}, 16'h0009);
        chk("p3x3_x", 16'(X), 16'h0);

        // S=7, then walk A=3 into B: add, 9 shifts.
        do_load(8'h07);
        do_add(0, 1);
        do_shift(9);
        chk("pre7x3_b", 16'(Bval), 16'h03);
        chk("pre7x3_a", 16'(Aval), 16'h00);
        run_mult();
        chk("p7x3", {Aval, Bval}, 16'h0015);
        chk("p7x3_x", 16'(X), 16'h0);

        // S=-3, build A=5 by +3 steps and shifts, then move it into B.
        do_load(8'hFD);
        do_add(1, 1); do_add(1, 1); do_add(1, 1);
        chk("sub_chain", 16'(Aval), 16'h09);
        do_shift(1);
        do_add(1, 1); do_add(1, 1);
        do_shift(1);
        chk("pre_m3x5_a", 16'(Aval), 16'h05);
        do_shift(8);
        chk("pre_m3x5_b", 16'(Bval), 16'h05);
        run_mult();
        chk("pm3x5", {Aval, Bval}, 16'hFFF1);
        chk("pm3x5_x", 16'(X), 16'h1);

        // Asynchronous reset mid-cycle, no clock edge in between.
        Reset = 1'b0;
        #1;
        chk("arst_a", 16'(Aval), 16'h00);
        chk("arst_b", 16'(Bval), 16'h00);
        chk("arst_x", 16'(X), 16'h0);
        chk("arst_m", 16'(M), 16'h0);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        chk("idle_ab", {Aval, Bval}, 16'h0000);

        // S=7, B=-2: A=-7, two arithmetic shifts to -2, then into B.
        do_load(8'h07);
        do_add(1, 1);
        chk("neg_a", 16'(Aval), 16'hF9);
        chk("neg_x", 16'(X), 16'h1);
        do_shift(2);
        chk("ashr_a", 16'(Aval), 16'hFE);
        do_shift(8);
        chk("pre7xm2_b", 16'(Bval), 16'hFE);
        chk("pre7xm2_a", 16'(Aval), 16'hFF);
        run_mult();
        chk("p7xm2", {Aval, Bval}, 16'hFFF2);
        chk("p7xm2_x", 16'(X), 16'h1);

        // Single add of -128, then shift keeps the sign via X.
        do_load(8'h80);
        do_add(0, 1);
        chk("add80_a", 16'(Aval), 16'h80);
        chk("add80_x", 16'(X), 16'h1);
        do_shift(1);
        chk("sh80_a", 16'(Aval), 16'hC0);
        chk("sh80_b", 16'(Bval), 16'h40);
        chk("sh80_x", 16'(X), 16'h1);
        chk("sh80_m", 16'(M), 16'h0);

        // Add_En=0 reload keeps A and copies its sign into X.
        do_raw(0, 0, 1, 0, 0, 0, 0);
        do_add(0, 0);
        chk("reload_a", 16'(Aval), 16'hC0);
        chk("reload_x", 16'(X), 16'h1);

        // Clears beat Ld_A.
        do_load(8'h12);
        do_add(1, 1);
        chk("sub12_a", 16'(Aval), 16'hEE);
        do_raw(0, 0, 1, 1, 0, 1, 0);
        chk("rx_ld_a", 16'(Aval), 16'hEE);
        chk("rx_ld_x", 16'(X), 16'h0);
        do_raw(0, 1, 1, 0, 0, 0, 0);
        do_add(0, 1);
        chk("add12_a", 16'(Aval), 16'h12);
        do_raw(0, 1, 0, 1, 0, 1, 0);
        chk("ra_ld_a", 16'(Aval), 16'h00);
        chk("ra_ld_x", 16'(X), 16'h0);

        // Reset_A with shift: B takes the pre-clear A[0].
        do_load(8'h03);
        do_add(0, 1);
        do_raw(0, 1, 0, 0, 0, 0, 1);
        chk("ra_sh_a", 16'(Aval), 16'h00);
        chk("ra_sh_b", 16'(Bval), 16'h81);

        // ClearA_LoadB beats Ld_A; S picks up the new switch value.
        do_add(0, 1);
        SW = 8'h44;
        do_raw(1, 0, 0, 1, 0, 1, 0);
        chk("cl_ld_b", 16'(Bval), 16'h44);
        chk("cl_ld_a", 16'(Aval), 16'h00);
        SW = 8'h99;
        do_add(0, 1);
        chk("cl_ld_s", 16'(Aval), 16'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Register/arithmetic datapath for the 8-bit signed add-shift multiplier, directly downstream of the multiplier control FSM.
- Holds the sign-extension bit X, accumulator A, multiplier B and a latched multiplicand S.
- Executes the FSM's reset, add/subtract-load and shift commands, and returns M = B[0] to the FSM.
- The 16-bit product {A,B} and X feed the hex display stage.

Parameters:
- W, 8, operand width; A, B and S are W bits, adder is W+1 bits.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- SW  in  W  switch value; source for both S and B loads.
- ClearA_LoadB  in  1  synchronous: S<=SW, B<=SW, A<=0, X<=0.
- Reset_A  in  1  synchronous clear of A.
- Reset_X  in  1  synchronous clear of X.
- Ld_A  in  1  load A and X from adder result.
- sub  in  1  adder subtracts S instead of adding.
- Add_En  in  1  adder operand select: 1 = S, 0 = zero.
- Shift_En  in  1  arithmetic right shift of {X,A,B}.
- Aval  out  W  accumulator A (product high half).
- Bval  out  W  register B (product low half).
- X  out  1  sign-extension flip-flop.
- M  out  1  combinational, equal to B[0].

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While Reset is low, A, B, S and X are 0 immediately, with no clock edge needed, so M = 0.
- All other updates occur on the rising edge of Clk.
- Adder is combinational, W+1 bits:
  - opA = {A[W-1], A}.
  - opS = Add_En ? {S[W-1], S} : 0.
  - sum = opA + (opS XOR {W+1{sub}}) + sub.
  - Carry-out beyond W+1 bits is discarded.
- Per-edge priority, highest first:
  1. Reset_A and/or Reset_X: clear the named register(s) only. B and S hold. Lower-priority actions on A/X are suppressed; a simultaneous shift still shifts B with A[0] taken as the pre-clear value.
  2. ClearA_LoadB: S<=SW, B<=SW, A<=0, X<=0.
  3. Ld_A: A<=sum[W-1:0], X<=sum[W]. B and S hold.
  4. Shift_En: X holds, A<={X, A[W-1:1]}, B<={A[0], B[W-1:1]}.
  5. None asserted: all registers hold.
- Ld_A and Shift_En asserted together: Ld_A wins and no shift occurs. The FSM never issues both at once; a bench assertion flags it.
- S changes only on ClearA_LoadB. Switch movement during a multiply has no effect.
- Ld_A with Add_En=0 reloads A with A (sign-preserved) and sets X = A[W-1].
- Latency:
  - Register outputs are visible one cycle after the command edge.
  - M follows B combinationally, so the FSM sees the new M in the state after a shift.
- A full multiply (1 reset cycle, 8 add + 8 shift states) leaves the signed 2W-bit product in {A,B}. add7 with sub=1 handles a negative multiplier MSB.
- Overflow is impossible by construction: the W+1-bit sign-extended sum is exact for one add or subtract.
- Reset asserted mid-operation clears immediately. After release the block idles with all registers at 0 until commanded.

Decomposition:
- Package mult_pkg holds:
  - localparam DATA_W = 8 (W defaults to it).
  - The W+1 sign-extension helper function.
- One sub-module, add_sub9: W+1-bit ripple add/subtract unit.
  - Ports A, S, sub, Add_En -> Sum (W+1 bits).
  - Built from full-adder bit slices.
  - Instanced once.
- Registers and priority mux stay in mult_datapath.

Test Plan:
- Reset low mid-run with A=0x55, B=0xAA, X=1, no clock edge -> A=0, B=0, X=0, M=0 within the same cycle.
- SW=0x07, pulse ClearA_LoadB; SW=0x03 then ClearA_LoadB again; replay the FSM command sequence -> S=0x03, B=0x03; sequence as driven ends with {A,B}=0x0009.
  - Variant: load S=0x07, B=0x03 via force, full multiply -> A=0x00, B=0x15, X=0.
- S=0xFD (-3), B=0x05, full 8-step sequence -> {A,B}=0xFFF1, X=1.
- S=0x07, B=0xFE (-2), sequence with sub=1 at add7 -> {A,B}=0xFFF2, X=1.
- Single step: A=0x00, S=0x80, Ld_A=Add_En=1, sub=0 -> A=0x80, X=1.
  - Then Shift_En with B=0x01 -> A=0xC0, B=0x00, X=1, M=0.
- Simultaneous Reset_A=1 and Ld_A=1 with A=0x12 -> A=0x00, X unchanged.
  - ClearA_LoadB with Ld_A, SW=0x44 -> B=0x44, S=0x44, A=0.
